jk_excitation_sequencer: RTL and testbench
==========================================

Name: jk_excitation_sequencer

Overview:
Inverse of the JK-from-D derivation: given a desired next state, produces the J/K excitation that drives an internal WIDTH-bit bank of JK-modelled state bits there. Accepts a target value over a valid/ready handshake. Walks the bank to the target either in one jump or by counting up one step per cycle. Used as the lab-sequence driver: J/K outputs feed the excitation-table checks, and Q feeds the display and counter logic.

Parameters:
WIDTH, 4, number of JK state bits in the bank (1..16)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  input  1  request strobe; target and mode qualified by this
req_target  input  WIDTH  desired final state
req_mode  input  1  0 = JUMP (single-step to target), 1 = COUNT (increment by 1 per cycle until target)
pause  input  1  while high in RUN, suppresses stepping (J=K=0, Q holds)
req_ready  output  1  high in IDLE; a request is accepted on an edge where req_valid & req_ready
busy  output  1  high in RUN
done  output  1  one-cycle pulse in the final RUN cycle, when Q == latched target
q  output  WIDTH  current state of the JK bank (registered)
j  output  WIDTH  per-bit J excitation applied at the next edge (combinational from state)
k  output  WIDTH  per-bit K excitation applied at the next edge

Behaviour:
- Reset (rst_n=0 at edge): q=0, state=IDLE, latched target=0, latched mode=0. In the following cycle: j=k=0, done=0, busy=0, req_ready=1.
- Bank update, per bit i, every edge with rst_n=1: q[i] <= (j[i] & ~q[i]) | (~k[i] & q[i]). Q must never be written by any other path.
- Excitation encoding (bit at q, desired d):
  - 0->0: J=0, K=0
  - 0->1: J=1, K=0
  - 1->0: J=0, K=1
  - 1->1: J=0, K=0
  - J=K=1 is never driven unless TOGGLE_EN is defined.
- FSM states: IDLE, RUN.
- IDLE:
  - j=k=0, busy=0, done=0, req_ready=1.
  - On an edge with req_valid=1: latch req_target and req_mode, go to RUN.
  - q is unchanged by acceptance.
- RUN, evaluated each cycle in priority order:
  1. If q == target: done=1, j=k=0. Next edge goes to IDLE. This applies even if pause=1.
  2. Else if pause=1: j=k=0, stay in RUN.
  3. Else JUMP: desired = target. q reaches target at the next edge.
  4. Else COUNT: desired = (q + 1) mod 2^WIDTH, wrapping from all-ones to 0.
- req_ready=0 in RUN; req_valid is ignored in RUN and is not queued.
- Latency, counted from the accept edge E0 to the done cycle:
  - JUMP with q != target: done in the 2nd cycle after E0.
  - Any request with q == target: done in the 1st cycle after E0.
  - COUNT: done in cycle (1 + ((target - q) mod 2^WIDTH)) after E0, plus one extra cycle per paused RUN cycle.
- Back-to-back: req_valid held high accepts a new request on the edge leaving the done cycle + 1, i.e. the first IDLE edge.
- Reset mid-RUN: abort with no done pulse; q=0, state IDLE.
- Width rule: all target/q comparisons and increments are unsigned WIDTH-bit; no carry out.

Optional Feature:
TOGGLE_EN. When defined, every changing bit is driven with J=1, K=1 (toggle), and non-changing bits with J=K=0. The q trajectory, done timing and all handshake behaviour are identical with and without the macro. Without it, the J/K encoding is exactly the set/reset table above.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with req_valid=1 -> q=0, j=k=0, busy=0, done=0, req_ready=1 after release.
- JUMP: q=0, request target=4'hA, mode=0 -> cycle 1: j=4'hA, k=4'h0. q=4'hA after the next edge; done=1 in cycle 2; IDLE in cycle 3.
- COUNT with wrap: from q=4'hE, request target=4'h1, mode=1 -> q steps E,F,0,1; done in cycle 4 after accept. Under TOGGLE_EN, at the F->0 step j=k=4'hF.
- Pause: COUNT 0->3 with pause high for 2 RUN cycles at q=1 -> q holds at 1 with j=k=0; done in cycle 6 after accept.
- Equal target: q=5, request target=5 (either mode) -> done in cycle 1, q unchanged, j=k=0 throughout.
- Reset mid-RUN: COUNT 0->F, assert rst_n=0 when q=6 -> q=0, no done pulse, req_ready=1 after release; a new JUMP to 3 then completes normally.

Source files
------------

// File: rtl/jk_excitation_sequencer_if.sv
// Request/status bundle for jk_excitation_sequencer.
// master drives requests and pause; slave presents handshake status, the JK bank and its excitation.
interface jk_excitation_sequencer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req_valid;
    logic [WIDTH-1:0] req_target;
    logic             req_mode;
    logic             pause;
    logic             req_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    modport master (
        output req_valid, req_target, req_mode, pause,
        input  req_ready, busy, done, q, j, k
    );

    modport slave (
        input  req_valid, req_target, req_mode, pause,
        output req_ready, busy, done, q, j, k
    );
endinterface

// File: rtl/jk_excitation_sequencer.sv
// Drives a WIDTH-bit JK-modelled bank to a requested target, by jump or by counting.
// Optional macro TOGGLE_EN: changing bits get J=K=1 instead of set/reset excitation.
module jk_excitation_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    jk_excitation_sequencer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] target_q;
    logic             mode_q;
    logic [WIDTH-1:0] desired;
    logic [WIDTH-1:0] j_exc, k_exc;
    logic             at_target;

    always_comb begin
        at_target = (q_q == target_q);
        desired   = q_q;
        j_exc     = '0;
        k_exc     = '0;
        // Target match outranks pause so done fires even while paused.
        if (state_q == RUN && !at_target && !bus.pause) begin
            desired = mode_q ? (q_q + WIDTH'(1)) : target_q;
`ifdef TOGGLE_EN
            j_exc = desired ^ q_q;
            k_exc = desired ^ q_q;
`else
            j_exc = desired & ~q_q;
            k_exc = ~desired & q_q;
`endif
        end
        q_d = (j_exc & ~q_q) | (~k_exc & q_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            q_q      <= '0;
            target_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            q_q <= q_d;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        target_q <= bus.req_target;
                        mode_q   <= bus.req_mode;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (at_target) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == RUN) && at_target;
    assign bus.q         = q_q;
    assign bus.j         = j_exc;
    assign bus.k         = k_exc;
endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Scoreboard bench: each request pushes its expected per-cycle RUN trajectory; a negedge monitor pops and compares.
module tb_jk_excitation_sequencer;
    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic         done;
    } rec_t;

    logic clk;
    logic rst_n;
    logic mon_en;
    logic [W-1:0] exp_q;
    rec_t sb[$];
    int n_tests;
    int n_fail;

    jk_excitation_sequencer_if #(.WIDTH(W)) bus ();

    jk_excitation_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_busy", 1, 0);
                end else begin
                    rec_t r;
                    r = sb.pop_front();
                    check("run_q", int'(bus.q), int'(r.q));
                    check("run_j", int'(bus.j), int'(r.j));
                    check("run_k", int'(bus.k), int'(r.k));
                    check("run_done", int'(bus.done), int'(r.done));
                    check("run_ready", int'(bus.req_ready), 0);
                end
            end else begin
                check("idle_q", int'(bus.q), int'(exp_q));
                check("idle_jk", int'({bus.j, bus.k}), 0);
                check("idle_done", int'(bus.done), 0);
                check("idle_ready", int'(bus.req_ready), 1);
            end
        end
    end

    // Called at #1 after an edge while the DUT is IDLE; returns at #1 after the last RUN edge.
    task automatic do_req(input logic [W-1:0] t, input logic m, input logic [63:0] pv, input int abort_c);
        logic [W-1:0] cq;
        logic [W-1:0] des;
        rec_t r;
        int len;
        cq  = exp_q;
        len = 0;
        for (int c = 1; c < 64; c++) begin
            r.q = cq;
            r.j = '0;
            r.k = '0;
            r.done = 1'b0;
            if (cq == t) begin
                r.done = 1'b1;
                sb.push_back(r);
                len = c;
                break;
            end
            if (!pv[c]) begin
                des = m ? W'(cq + 1) : t;
`ifdef TOGGLE_EN
                r.j = des ^ cq;
                r.k = des ^ cq;
`else
                r.j = des & ~cq;
                r.k = ~des & cq;
`endif
                cq = des;
            end
            sb.push_back(r);
        end

        bus.req_valid  = 1'b1;
        bus.req_target = t;
        bus.req_mode   = m;
        bus.pause      = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= len; c++) begin
            bus.req_valid  = 1'($urandom);
            bus.req_target = W'($urandom);
            bus.req_mode   = 1'($urandom);
            bus.pause      = pv[c];
            if (c == abort_c) rst_n = 1'b0;
            @(posedge clk); #1;
            if (c == abort_c) begin
                rst_n         = 1'b1;
                bus.req_valid = 1'b0;
                bus.pause     = 1'b0;
                sb.delete();
                exp_q = '0;
                return;
            end
        end
        bus.req_valid = 1'b0;
        bus.pause     = 1'b0;
        exp_q = t;
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [63:0] pv;
        n_tests = 0;
        n_fail  = 0;
        mon_en  = 1'b0;
        exp_q   = '0;
        rst_n   = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_target = 4'h7;
        bus.req_mode   = 1'b0;
        bus.pause      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        mon_en = 1'b1;
        idle(2);

        do_req(4'hA, 1'b0, 64'h0, 0);
        idle(1);
        do_req(4'hE, 1'b0, 64'h0, 0);
        do_req(4'h1, 1'b1, 64'h0, 0);
        do_req(4'h0, 1'b0, 64'h0, 0);
        do_req(4'h3, 1'b1, 64'h0C, 0);
        do_req(4'h5, 1'b0, 64'h0, 0);
        do_req(4'h5, 1'b0, 64'h0, 0);
        do_req(4'h5, 1'b1, 64'h2, 0);
        do_req(4'h0, 1'b0, 64'h0, 0);
        do_req(4'hF, 1'b1, 64'h0, 7);
        idle(1);
        do_req(4'h3, 1'b0, 64'h0, 0);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            pv = '0;
            for (int c = 1; c < 40; c++) pv[c] = ($urandom_range(0, 3) == 0);
            do_req(W'($urandom), 1'($urandom), pv, 0);
            idle($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
